// File: rtl/cnt_burst_arbiter.sv
// Round-robin arbiter that lends one shared event counter to NREQ requesters,
// running a clear / N-pulse / capture / stop burst on behalf of each winner.
module cnt_burst_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 8,
  parameter int GAP  = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [CW-1:0]     result,
  output logic              err,
  output logic              busy,
  output logic              cnt_res,
  output logic              cnt_stop,
  output logic              cnt_vin,
  input  logic [CW-1:0]     cnt_data
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    VIN_HI,
    VIN_LO,
    CAPTURE,
    STOP
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    last_q;
  logic [CW-1:0]    rem_q;
  logic [CW-1:0]    exp_q;
  logic [GW-1:0]    gap_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic [CW-1:0]    result_q;
  logic             err_q;
  logic             busy_q;
  logic             cntRes_q;
  logic             cntStop_q;
  logic             cntVin_q;

  logic             winValid_d;
  logic [IW-1:0]    winIdx_d;
  logic [CW-1:0]    lenSel_d;
  int               idx;

  // Search last+1, last+2, ... so the nearest requester after the previous
  // winner takes priority; scanning downward lets the smallest offset win.
  always_comb begin
    winValid_d = 1'b0;
    winIdx_d   = '0;
    lenSel_d   = '0;
    idx        = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NREQ;
      if (req[IW'(idx)]) begin
        winValid_d = 1'b1;
        winIdx_d   = IW'(idx);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == winIdx_d) lenSel_d = len[i*CW +: CW];
    end
  end

  // Each output register is loaded on the edge that enters the state in which
  // it must be visible, so every output is a clean flop.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      last_q    <= IW'(NREQ - 1);
      rem_q     <= '0;
      exp_q     <= '0;
      gap_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cntRes_q  <= 1'b1;
      cntStop_q <= 1'b0;
      cntVin_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cntRes_q <= 1'b0;
          if (winValid_d) begin
            rem_q    <= lenSel_d;
            exp_q    <= lenSel_d;
            last_q   <= winIdx_d;
            gnt_q    <= NREQ'(1) << winIdx_d;
            busy_q   <= 1'b1;
            cntRes_q <= 1'b1;
            state_q  <= CLEAR;
          end
        end
        CLEAR: begin
          cntRes_q <= 1'b0;
          if (rem_q != '0) begin
            cntVin_q <= 1'b1;
            state_q  <= VIN_HI;
          end else begin
            state_q  <= CAPTURE;
          end
        end
        VIN_HI: begin
          cntVin_q <= 1'b0;
          if (rem_q != '0) rem_q <= rem_q - CW'(1);
          gap_q    <= GW'(GAP - 1);
          state_q  <= VIN_LO;
        end
        VIN_LO: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - GW'(1);
          end else if (rem_q != '0) begin
            cntVin_q <= 1'b1;
            state_q  <= VIN_HI;
          end else begin
            state_q  <= CAPTURE;
          end
        end
        // Sample the counter before stop is raised, since stop clears it.
        CAPTURE: begin
          result_q  <= cnt_data;
          err_q     <= (cnt_data != exp_q);
          done_q    <= gnt_q;
          cntStop_q <= 1'b1;
          state_q   <= STOP;
        end
        STOP: begin
          gnt_q     <= '0;
          done_q    <= '0;
          err_q     <= 1'b0;
          busy_q    <= 1'b0;
          cntStop_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign result   = result_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign cnt_res  = cntRes_q;
  assign cnt_stop = cntStop_q;
  assign cnt_vin  = cntVin_q;

endmodule

// File: tb/tb_cnt_burst_arbiter.sv
// Directed bench for cnt_burst_arbiter with a behavioural event counter
// that can be told to swallow one vin edge.
module tb_cnt_burst_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int GAP  = 1;

  logic               clk = 1'b0;
  logic               res;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [CW-1:0]      result;
  logic               err;
  logic               busy;
  logic               cnt_res;
  logic               cnt_stop;
  logic               cnt_vin;
  logic [CW-1:0]      cnt_data;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] count;
  logic          vinPrev;
  logic          dropReq = 1'b0;
  logic          dropDone = 1'b0;

  always #5 clk = ~clk;

  cnt_burst_arbiter #(.NREQ(NREQ), .CW(CW), .GAP(GAP)) dut (
    .clk      (clk),
    .res      (res),
    .req      (req),
    .len      (len),
    .gnt      (gnt),
    .done     (done),
    .result   (result),
    .err      (err),
    .busy     (busy),
    .cnt_res  (cnt_res),
    .cnt_stop (cnt_stop),
    .cnt_vin  (cnt_vin),
    .cnt_data (cnt_data)
  );

  // Counter model: counts vin rising edges, cleared by res or stop.
  always @(posedge clk) begin
    vinPrev <= cnt_vin;
    if (cnt_res || cnt_stop) begin
      count <= '0;
    end else if (cnt_vin && !vinPrev) begin
      if (dropReq && !dropDone) dropDone <= 1'b1;
      else count <= count + 1'b1;
    end
  end
  assign cnt_data = count;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Waits for a grant, then follows it to its end, sampling on falling edges.
  task automatic measureBurst(output int width, output int idle, output int vins, output int edges,
                              output int doneCount, output int errCount, output int bad,
                              output logic [NREQ-1:0] seen, output bit doneLast, output bit errWithDone);
    logic prev;
    int guard;
    width = 0; idle = 0; vins = 0; edges = 0; doneCount = 0; errCount = 0; bad = 0;
    seen = '0; doneLast = 1'b0; errWithDone = 1'b0; prev = 1'b0;
    guard = 0;
    while (gnt == '0 && guard < 100) begin
      idle++; guard++;
      @(negedge clk);
    end
    if (gnt == '0) begin
      errors++;
      $error("[TB] FAIL grantTimeout observed=none required=grant");
      return;
    end
    guard = 0;
    while (gnt != '0 && guard < 2000) begin
      width++;
      seen |= gnt;
      if (cnt_vin) vins++;
      if (cnt_vin && !prev) edges++;
      prev = cnt_vin;
      if ($countones(gnt) != 1 || busy !== 1'b1) bad++;
      doneLast = (done == gnt);
      if (done != '0) doneCount++;
      if (err) errCount++;
      if (err && done != '0) errWithDone = 1'b1;
      guard++;
      @(negedge clk);
    end
    if (guard >= 2000) begin
      errors++;
      $error("[TB] FAIL burstTimeout observed=stuck required=release");
    end
  endtask

  task automatic applyStimulus(input string tag, input int expLen, input logic [NREQ-1:0] expGnt,
                               input int expResult, input bit expErr, output int idle);
    int width, vins, edges, doneCount, errCount, bad;
    logic [NREQ-1:0] seen;
    bit doneLast, errWithDone;
    measureBurst(width, idle, vins, edges, doneCount, errCount, bad, seen, doneLast, errWithDone);
    checkOutput({tag, ".width"},    width,     3 + expLen * (1 + GAP));
    checkOutput({tag, ".vinHigh"},  vins,      expLen);
    checkOutput({tag, ".vinEdges"}, edges,     expLen);
    checkOutput({tag, ".gnt"},      32'(seen), 32'(expGnt));
    checkOutput({tag, ".doneCnt"},  doneCount, 1);
    checkOutput({tag, ".doneLast"}, 32'(doneLast), 1);
    checkOutput({tag, ".oneHot"},   bad,       0);
    checkOutput({tag, ".result"},   32'(result), expResult);
    checkOutput({tag, ".errCnt"},   errCount,  32'(expErr));
    checkOutput({tag, ".errDone"},  32'(errWithDone), 32'(expErr));
    checkOutput({tag, ".busyIdle"}, 32'(busy), 0);
  endtask

  initial begin
    int idle;
    int n;
    int guard;
    res = 1'b1;
    req = '0;
    len = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst.gnt",    32'(gnt), 0);
    checkOutput("rst.done",   32'(done), 0);
    checkOutput("rst.result", 32'(result), 0);
    checkOutput("rst.err",    32'(err), 0);
    checkOutput("rst.busy",   32'(busy), 0);
    checkOutput("rst.cntRes", 32'(cnt_res), 1);
    checkOutput("rst.stop",   32'(cnt_stop), 0);
    checkOutput("rst.vin",    32'(cnt_vin), 0);
    res = 1'b0;
    @(negedge clk);

    // Single request of five events.
    len[0*CW +: CW] = 8'd5;
    req = 4'b0001;
    applyStimulus("single", 5, 4'b0001, 5, 1'b0, idle);
    req = '0;

    // Zero-length burst.
    len[2*CW +: CW] = 8'd0;
    req = 4'b0100;
    applyStimulus("zero", 0, 4'b0100, 0, 1'b0, idle);
    req = '0;

    // Round-robin from a fresh reset so requester 0 leads.
    res = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = CW'(i + 1);
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      applyStimulus($sformatf("rr%0d", b), (b % 4) + 1, NREQ'(1) << (b % 4), (b % 4) + 1, 1'b0, idle);
      if (b > 0) checkOutput($sformatf("rr%0d.idle", b), idle, 1);
      if (b == 4) req = '0;
    end

    // Reset in the middle of a burst of ten.
    len[1*CW +: CW] = 8'd10;
    req = 4'b0010;
    n = 0;
    guard = 0;
    vinPrev_wait: while (n < 4 && guard < 200) begin
      @(negedge clk);
      if (cnt_vin) n++;
      guard++;
    end
    checkOutput("abort.pulses", n, 4);
    res = 1'b1;
    @(negedge clk);
    checkOutput("abort.gnt",    32'(gnt), 0);
    checkOutput("abort.busy",   32'(busy), 0);
    checkOutput("abort.cntRes", 32'(cnt_res), 1);
    checkOutput("abort.done",   32'(done), 0);
    checkOutput("abort.vin",    32'(cnt_vin), 0);
    res = 1'b0;
    applyStimulus("retry", 10, 4'b0010, 10, 1'b0, idle);
    req = '0;

    // Counter swallows one edge: result falls short and err fires.
    dropReq = 1'b1;
    len[3*CW +: CW] = 8'd6;
    req = 4'b1000;
    applyStimulus("drop", 6, 4'b1000, 5, 1'b1, idle);
    req = '0;
    checkOutput("drop.used", 32'(dropDone), 1);

    // req and len change under an active grant; original length must stick.
    len[0*CW +: CW] = 8'd7;
    req = 4'b0001;
    guard = 0;
    while (gnt == '0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req = '0;
    len[0*CW +: CW] = 8'd200;
    applyStimulus("churn", 7, 4'b0001, 7, 1'b0, idle);

    // Longest burst must not wrap.
    len[0*CW +: CW] = 8'd255;
    req = 4'b0001;
    applyStimulus("max", 255, 4'b0001, 255, 1'b0, idle);
    req = '0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_burst_arbiter.md
Name: cnt_burst_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit event counter (inputs clk/res/stop/vin, outputs dataout/valid1) between NREQ requesters.
- A granted requester asks for a burst of N events. The block clears the counter, issues N vin pulses, reads back dataout, checks it against N, then stops the counter and releases the grant.
- Sits between requester blocks and the counter instance. It is the only driver of the counter's res/stop/vin.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 8, burst length / counter data width; fixed to the counter's dataout width.
- GAP, 1, low cycles between vin pulses (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- res  input  1  synchronous active-high reset
- req  input  NREQ  per-requester request level
- len  input  NREQ*CW  burst length per requester; slice i = len[i*CW +: CW]
- gnt  output  NREQ  one-hot grant
- done  output  NREQ  one-cycle completion pulse for the granted requester
- result  output  CW  counter value captured for the last burst
- err  output  1  one-cycle pulse with done when result != latched len
- busy  output  1  high whenever the FSM is not in IDLE
- cnt_res  output  1  drives counter res
- cnt_stop  output  1  drives counter stop
- cnt_vin  output  1  drives counter vin
- cnt_data  input  CW  counter dataout

Behaviour:
- All outputs are registered.
- Reset values while res=1:
  - gnt=0, done=0, result=0, err=0, busy=0, cnt_stop=0, cnt_vin=0.
  - cnt_res=1: the counter is cleared during reset.
  - FSM goes to IDLE; round-robin pointer last=NREQ-1, so req[0] has first priority after reset.
- Reset mid-burst aborts immediately. No done or err is issued for the aborted burst.
- FSM states: IDLE, CLEAR, VIN_HI, VIN_LO, CAPTURE, STOP.
- IDLE:
  - If any req bit is set, select the winner as the first set bit searching last+1, last+2, … modulo NREQ.
  - Latch rem = len[winner] and exp = len[winner]; set gnt[winner]=1 and last=winner; go to CLEAR.
  - If no req bit is set, stay in IDLE.
- CLEAR (1 cycle): cnt_res=1. Next state is VIN_HI if rem!=0, else CAPTURE.
- VIN_HI (1 cycle): cnt_vin=1, rem <= rem-1. Next state is VIN_LO.
- VIN_LO (GAP cycles): cnt_vin=0. After GAP cycles, go to VIN_HI if rem!=0, else CAPTURE.
- CAPTURE (1 cycle): result <= cnt_data. This happens before stop is raised, because stop clears the counter.
- STOP (1 cycle):
  - cnt_stop=1, done[winner]=1, err = (result != exp).
  - gnt[winner] stays high through this cycle; all gnt bits are 0 in the following cycle.
  - Next state is IDLE.
- gnt timing for a burst of length L: gnt is high for exactly 3 + L*(1+GAP) cycles.
- len=0: no vin pulses; gnt is high for 3 cycles; result is expected to be 0.
- Re-arbitration: IDLE always lasts at least 1 cycle between bursts. A requester that holds req after done is re-granted only after the other pending requesters have been served in round-robin order.
- req and len are sampled only in IDLE. Changes to either while granted, including req dropping, are ignored, and the burst runs to completion.
- result holds its value until the next CAPTURE. err and done are single-cycle pulses.
- rem is CW bits wide and never wraps: it decrements only when nonzero. The maximum burst of 2^CW-1 fits the counter without overflow.
- cnt_res, cnt_stop and cnt_vin are mutually exclusive, except that cnt_res=1 during reset.
- Exactly one gnt bit is high whenever busy=1; no gnt bit is high in IDLE.

Test Plan:
- Single request, GAP=1: req[0]=1, len[0]=5 -> gnt=0001 for 13 cycles, 5 cnt_vin pulses each 1 high/1 low, result=5, err=0, done[0] pulses in the last gnt cycle.
- Zero length: req[2]=1, len[2]=0 -> gnt=0100 for 3 cycles, no cnt_vin, result=0, err=0.
- Round-robin with all requests held, lens 1/2/3/4 -> grant order 0,1,2,3,0; each gnt width matches 3+2L; exactly one IDLE cycle between grants; results 1,2,3,4.
- Reset mid-burst: req[1]=1, len[1]=10, assert res after the 4th vin pulse -> next cycle gnt=0, busy=0, cnt_res=1, no done. After reset release with req[1] held, a fresh burst of 10 completes with result=10.
- Error detection: counter model drops one vin edge, len=6 -> result=5, err=1 coincident with done.
- Request churn: drop req[0] mid-burst and change len[0] mid-burst -> burst completes with the original len. Max length len=255 -> result=255, err=0, no wrap.
